// File: rtl/ram_reader_if.sv
// ram_reader_if: command, memory-read and stream signals of a ram_reader (slave) and its host/consumer (master)
interface ram_reader_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_valid;
  logic             out_ready;
  modport master (
    output start, base, count, mem_in, out_ready,
    input  busy, done, mem_addr, out_data, out_addr, out_valid
  );
  modport slave (
    input  start, base, count, mem_in, out_ready,
    output busy, done, mem_addr, out_data, out_addr, out_valid
  );
endinterface

// File: rtl/ram_reader.sv
// ram_reader: streams COUNT words from BASE of a combinational-read RAM over valid/ready
// Optional running checksum port sum when RAM_READER_CKSUM_EN is defined.
module ram_reader #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input logic       clk,
  input logic       rst_n,
  ram_reader_if.slave bus
`ifdef RAM_READER_CKSUM_EN
  ,
  output logic [WIDTH-1:0] sum
`endif
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t      state;
  logic [AW:0] remaining;
  logic        capture;
  // the output register is free when empty or being drained this cycle
  assign capture = (state == READ) && (!bus.out_valid || bus.out_ready);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.mem_addr <= bus.base;
          remaining    <= bus.count;
          if (bus.count == '0) bus.done <= 1'b1;
          else begin
            state    <= READ;
            bus.busy <= 1'b1;
          end
        end
        READ: if (capture) begin
          bus.out_data  <= bus.mem_in;
          bus.out_addr  <= bus.mem_addr;
          bus.out_valid <= 1'b1;
          bus.mem_addr  <= bus.mem_addr + 1'b1;
          remaining     <= remaining - 1'b1;
          if (remaining == (AW+1)'(1)) state <= DRAIN;
        end
        DRAIN: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef RAM_READER_CKSUM_EN
  always_ff @(posedge clk)
    if (!rst_n) sum <= '0;
    else if (state == IDLE && bus.start) sum <= '0;
    else if (capture) sum <= sum + bus.mem_in;
`endif
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: scoreboard bench; stimulus queues expected beats, a negedge monitor pops and compares
module tb_ram_reader;
  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  logic [WIDTH-1:0] mem [DEPTH];
  assign bus.mem_in = mem[bus.mem_addr];
`ifdef RAM_READER_CKSUM_EN
  logic [WIDTH-1:0] sum;
  ram_reader #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .sum(sum));
`else
  ram_reader #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  int    checks = 0;
  int    passes = 0;
  int    beats = 0;
  int    dones = 0;
  int    exp_dones = 0;
  int    cyc = 0;
  int    cyc_q[$];
  beat_t exp_q[$];
  beat_t held;
  logic  held_pend = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) held_pend = 1'b0;
    else begin
      if (bus.done) begin
        dones++;
        check("done_after_beats", exp_q.size(), 0);
      end
      if (bus.out_valid) begin
        if (held_pend) check("stall_hold", {bus.out_addr, bus.out_data}, held);
        held_pend = !bus.out_ready;
        held = {bus.out_addr, bus.out_data};
        if (bus.out_ready) begin
          beats++;
          cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got addr %0d data %0h, none expected", bus.out_addr, bus.out_data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat", {bus.out_addr, bus.out_data}, e);
          end
        end
      end else held_pend = 1'b0;
    end
  end
  task automatic cmd(input logic [AW-1:0] b, input logic [AW:0] c);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    a = b;
    for (int i = 0; i < int'(c); i++) begin
      exp_q.push_back({a, mem[a]});
      a++;
    end
    bus.start = 1'b1;
    bus.base  = b;
    bus.count = c;
    exp_dones++;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      $display("FAIL %s: done not seen within 40 cycles", name);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    bus.start = 1'b1;
    bus.base = '0;
    bus.count = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(100 + i);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    // full block, consumer always ready
    cyc_q.delete();
    cmd(0, 8);
    check("t2_valid_early", bus.out_valid, 0);
    @(posedge clk); #1;
    check("t2_valid_latency", bus.out_valid, 1);
    repeat (7) @(posedge clk);
    #1;
    check("t2_done_early", bus.done, 0);
    @(posedge clk); #1;
    check("t2_done", bus.done, 1);
    check("t2_busy_fall", bus.busy, 0);
    @(posedge clk); #1;
    check("t2_done_pulse", bus.done, 0);
    check("t2_beat_total", cyc_q.size(), 8);
    if (cyc_q.size() == 8) check("t2_throughput", cyc_q[7] - cyc_q[0], 7);
    check("t2_done_count", dones, exp_dones);
    // wrapping block with distinct data
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(16'h1000 * (i + 1) + i);
    cmd(6, 4);
    wait_done("t3_done");
    check("t3_done_count", dones, exp_dones);
    check("t3_queue_empty", exp_q.size(), 0);
    // back-pressure
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(100 + i);
    bus.out_ready = 1'b0;
    cmd(5, 3);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_capture", bus.mem_addr, 6);
    check("t4_valid", bus.out_valid, 1);
    check("t4_addr", bus.out_addr, 5);
    check("t4_data", bus.out_data, 105);
    bus.out_ready = 1'b1;
    wait_done("t4_done");
    check("t4_done_count", dones, exp_dones);
    check("t4_queue_empty", exp_q.size(), 0);
    // zero-length command
    cmd(3, 0);
    check("t5_done", bus.done, 1);
    check("t5_busy", bus.busy, 0);
    check("t5_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("t5_done_pulse", bus.done, 0);
    check("t5_valid_after", bus.out_valid, 0);
    check("t5_done_count", dones, exp_dones);
    // abort mid-transfer, then a fresh command
    begin
      int n = 0;
      int b0 = beats;
      cmd(0, 8);
      while (beats < b0 + 2 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      if (beats < b0 + 2) begin
        checks++;
        $display("FAIL t6_beats: saw %0d beats, need 2", beats - b0);
      end
    end
    rst_n = 1'b0;
    exp_dones--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("t6_abort_valid", bus.out_valid, 0);
    check("t6_abort_busy", bus.busy, 0);
    cmd(2, 2);
    wait_done("t6_done");
    check("t6_done_count", dones, exp_dones);
    check("t6_queue_empty", exp_q.size(), 0);
`ifdef RAM_READER_CKSUM_EN
    check("t6_sum", sum, 205);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
